mem_prog_loader: RTL and testbench



---
 rtl/mem_prog_loader_if.sv | 41 ++++
 rtl/mem_prog_loader.sv | 207 ++++++++++++++++++++
 tb/tb_mem_prog_loader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_prog_loader_if.sv
// ============================================================================
// Module      : mem_prog_loader_if
// Description : Bundle of byte-stream handshake, inst/data memory write
//               ports and CPU-release/status signals of the program loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_prog_loader_if #(
  parameter int ADDR_W = 12
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] i_addr;
  logic [7:0]        i_wr_data;
  logic              i_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [7:0]        m_wr_data;
  logic              m_wr;
  logic              cpu_reset_;
  logic              busy;
  logic              err;
  logic              overflow;

  // Host side: supplies the byte stream and observes everything else.
  modport master (
    output in_data, in_valid,
    input  in_ready, i_addr, i_wr_data, i_wr, m_addr, m_wr_data, m_wr,
    input  cpu_reset_, busy, err, overflow
  );

  // Loader side.
  modport slave (
    input  in_data, in_valid,
    output in_ready, i_addr, i_wr_data, i_wr, m_addr, m_wr_data, m_wr,
    output cpu_reset_, busy, err, overflow
  );
endinterface

`default_nettype wire

// File: rtl/mem_prog_loader.sv
// ============================================================================
// Module      : mem_prog_loader
// Description : Consumes a command/length/payload byte stream and writes the
//               instruction and data memories; on 'G' counts a cool-off
//               period and then releases the CPU reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_prog_loader #(
  parameter int ADDR_W    = 12,
  parameter int MAX_MEM   = 2048,
  parameter int DATA_BASE = 8,
  parameter int COOLOFF   = 32
) (
  input  wire logic         clk,
  input  wire logic         reset,
  mem_prog_loader_if.slave  bus
);

  localparam int CNT_W = (COOLOFF > 1) ? $clog2(COOLOFF) : 1;
  localparam int SUM_W = ADDR_W + 1;

  localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(COOLOFF - 1);
  localparam logic [SUM_W-1:0] c_max_mem   = SUM_W'(MAX_MEM);
  localparam logic [SUM_W-1:0] c_data_base = SUM_W'(DATA_BASE);
  localparam logic [7:0]       c_cmd_inst  = 8'h49;
  localparam logic [7:0]       c_cmd_data  = 8'h44;
  localparam logic [7:0]       c_cmd_go    = 8'h47;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_PAYLOAD = 3'd3,
    S_COOLOFF = 3'd4,
    S_RUN     = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_tgt_data;   // 1: current section targets data memory
  logic [11:0]       r_len;
  logic [11:0]       r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic              r_overflow;
  logic [ADDR_W-1:0] r_i_addr;
  logic [7:0]        r_i_wr_data;
  logic              r_i_wr;
  logic [ADDR_W-1:0] r_m_addr;
  logic [7:0]        r_m_wr_data;
  logic              r_m_wr;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_busy;
  logic              w_cpu_run;
  logic [SUM_W-1:0]  w_base;
  logic [SUM_W-1:0]  w_sum;
  logic              w_in_range;
  logic              w_idx_last;
  logic [11:0]       w_len_full;

  // Only the cool-off and run phases refuse bytes; ERR keeps draining.
  assign w_in_ready = (r_state != S_COOLOFF) && (r_state != S_RUN);
  assign w_accept   = bus.in_valid & w_in_ready;

  // One bit wider than the address so base + idx can never wrap into range.
  assign w_base     = r_tgt_data ? c_data_base : '0;
  assign w_sum      = w_base + SUM_W'(r_idx);
  assign w_in_range = (w_sum < c_max_mem);
  assign w_idx_last = (r_idx == (r_len - 12'd1));
  assign w_len_full = {r_len[11:8], bus.in_data};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode plus state-derived outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_cpu_run   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (bus.in_data == c_cmd_inst || bus.in_data == c_cmd_data)
            w_state_nxt = S_LEN_HI;
          else if (bus.in_data == c_cmd_go)
            w_state_nxt = S_COOLOFF;
          else
            w_state_nxt = S_ERR;
        end
      end
      S_LEN_HI: begin
        w_busy = 1'b1;
        if (w_accept)
          w_state_nxt = (bus.in_data[7:4] != 4'h0) ? S_ERR : S_LEN_LO;
      end
      S_LEN_LO: begin
        w_busy = 1'b1;
        if (w_accept)
          w_state_nxt = (w_len_full == 12'd0) ? S_IDLE : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        w_busy = 1'b1;
        if (w_accept && w_idx_last)
          w_state_nxt = S_IDLE;
      end
      S_COOLOFF: begin
        if (r_cnt == c_cnt_last)
          w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_cpu_run = 1'b1;
      end
      S_ERR: begin
        w_state_nxt = S_ERR;
      end
      default: begin
        w_state_nxt = S_ERR;
      end
    endcase
  end

  // Section bookkeeping, cool-off counter, sticky flags and registered
  // memory write ports (strobes last exactly one cycle per accepted byte).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tgt_data  <= 1'b0;
      r_len       <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_overflow  <= 1'b0;
      r_i_addr    <= '0;
      r_i_wr_data <= '0;
      r_i_wr      <= 1'b0;
      r_m_addr    <= '0;
      r_m_wr_data <= '0;
      r_m_wr      <= 1'b0;
    end else begin
      r_i_wr <= 1'b0;
      r_m_wr <= 1'b0;
      r_err  <= r_err | (w_state_nxt == S_ERR);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (bus.in_data == c_cmd_inst) r_tgt_data <= 1'b0;
            if (bus.in_data == c_cmd_data) r_tgt_data <= 1'b1;
            if (bus.in_data == c_cmd_go)   r_cnt      <= '0;
          end
        end
        S_LEN_HI: begin
          if (w_accept) r_len[11:8] <= bus.in_data[3:0];
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_len[7:0] <= bus.in_data;
            r_idx      <= '0;
          end
        end
        S_PAYLOAD: begin
          if (w_accept) begin
            r_idx <= r_idx + 12'd1;
            if (!w_in_range) begin
              r_overflow <= 1'b1;
            end else if (r_tgt_data) begin
              r_m_addr    <= w_sum[ADDR_W-1:0];
              r_m_wr_data <= bus.in_data;
              r_m_wr      <= 1'b1;
            end else begin
              r_i_addr    <= w_sum[ADDR_W-1:0];
              r_i_wr_data <= bus.in_data;
              r_i_wr      <= 1'b1;
            end
          end
        end
        S_COOLOFF: begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.busy       = w_busy;
  assign bus.cpu_reset_ = w_cpu_run;
  assign bus.err        = r_err;
  assign bus.overflow   = r_overflow;
  assign bus.i_addr     = r_i_addr;
  assign bus.i_wr_data  = r_i_wr_data;
  assign bus.i_wr       = r_i_wr;
  assign bus.m_addr     = r_m_addr;
  assign bus.m_wr_data  = r_m_wr_data;
  assign bus.m_wr       = r_m_wr;

endmodule

`default_nettype wire

// File: tb/tb_mem_prog_loader.sv
// ============================================================================
// Module      : tb_mem_prog_loader
// Description : Directed sequence with randomized payloads for the program
//               loader; expected memory contents come from a flat array model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_prog_loader;
  localparam int ADDR_W    = 12;
  localparam int MAX_MEM   = 2048;
  localparam int DATA_BASE = 8;
  localparam int COOLOFF   = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_prog_loader_if #(.ADDR_W(ADDR_W)) bus();

  mem_prog_loader #(
    .ADDR_W(ADDR_W), .MAX_MEM(MAX_MEM), .DATA_BASE(DATA_BASE), .COOLOFF(COOLOFF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] model_i [4096];
  logic [7:0] model_d [4096];
  logic [7:0] sh_i    [4096];
  logic [7:0] sh_d    [4096];
  int         n_iwr = 0;
  int         n_mwr = 0;
  bit         both_hi = 1'b0;
  logic [7:0] pay [$];

  // Memories as seen through the write ports.
  always @(negedge clk) begin
    if (bus.i_wr === 1'b1) begin sh_i[bus.i_addr] = bus.i_wr_data; n_iwr++; end
    if (bus.m_wr === 1'b1) begin sh_d[bus.m_addr] = bus.m_wr_data; n_mwr++; end
    if (bus.i_wr === 1'b1 && bus.m_wr === 1'b1) both_hi = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a byte until it is accepted; returns at the negedge after the accepting edge.
  task automatic put(input logic [7:0] b);
    bit   done;
    logic rdy;
    done = 1'b0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 64 && !done; t++) begin
      rdy = bus.in_ready;
      @(posedge clk);
      @(negedge clk);
      if (rdy === 1'b1) done = 1'b1;
    end
    bus.in_valid = 1'b0;
    chk("accept", 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("idle_no_strobe", {30'd0, bus.i_wr, bus.m_wr}, 32'd0);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic fill_random(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  task automatic check_mem();
    int bad;
    bad = 0;
    for (int a = 0; a < MAX_MEM; a++) begin
      if (sh_i[a] !== model_i[a]) bad++;
      if (sh_d[a] !== model_d[a]) bad++;
    end
    chk("mem_readback", 32'(bad), 32'd0);
  endtask

  // gap: 0 = back-to-back, 1 = one idle cycle before every byte, 2 = random idles.
  task automatic load_section(input bit tgt, input logic [11:0] len, input int gap);
    int a;
    put(tgt ? 8'h44 : 8'h49);
    chk("busy_len_hi", 32'(bus.busy), 32'd1);
    put({4'h0, len[11:8]});
    put(len[7:0]);
    if (len == 12'd0) chk("busy_zero_len", 32'(bus.busy), 32'd0);
    for (int k = 0; k < int'(len); k++) begin
      if (gap == 1) idle(1);
      else if (gap == 2 && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      put(pay[k]);
      a = (tgt ? DATA_BASE : 0) + k;
      if (a < MAX_MEM) begin
        if (tgt) begin
          chk("m_wr", 32'(bus.m_wr), 32'd1);
          chk("i_wr_quiet", 32'(bus.i_wr), 32'd0);
          chk("m_addr", 32'(bus.m_addr), 32'(a));
          chk("m_wr_data", 32'(bus.m_wr_data), 32'(pay[k]));
          model_d[a] = pay[k];
        end else begin
          chk("i_wr", 32'(bus.i_wr), 32'd1);
          chk("m_wr_quiet", 32'(bus.m_wr), 32'd0);
          chk("i_addr", 32'(bus.i_addr), 32'(a));
          chk("i_wr_data", 32'(bus.i_wr_data), 32'(pay[k]));
          model_i[a] = pay[k];
        end
      end else begin
        chk("dropped_no_strobe", {30'd0, bus.i_wr, bus.m_wr}, 32'd0);
        chk("overflow_set", 32'(bus.overflow), 32'd1);
      end
      chk("busy_payload", 32'(bus.busy), (k == int'(len) - 1) ? 32'd0 : 32'd1);
    end
  endtask

  initial begin
    int n0;
    bit tgt;
    int len;
    for (int a = 0; a < 4096; a++) begin
      model_i[a] = 8'h00; model_d[a] = 8'h00; sh_i[a] = 8'h00; sh_d[a] = 8'h00;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_in_ready",   32'(bus.in_ready),   32'd1);
    chk("rst_i_wr",       32'(bus.i_wr),       32'd0);
    chk("rst_m_wr",       32'(bus.m_wr),       32'd0);
    chk("rst_i_addr",     32'(bus.i_addr),     32'd0);
    chk("rst_m_addr",     32'(bus.m_addr),     32'd0);
    chk("rst_i_wr_data",  32'(bus.i_wr_data),  32'd0);
    chk("rst_m_wr_data",  32'(bus.m_wr_data),  32'd0);
    chk("rst_cpu_reset_", 32'(bus.cpu_reset_), 32'd0);
    chk("rst_busy",       32'(bus.busy),       32'd0);
    chk("rst_err",        32'(bus.err),        32'd0);
    chk("rst_overflow",   32'(bus.overflow),   32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Inst section AA BB CC, then data 11 22 with alternating valid
    pay = '{8'hAA, 8'hBB, 8'hCC};
    load_section(1'b0, 12'd3, 0);
    pay = '{8'h11, 8'h22};
    load_section(1'b1, 12'd2, 1);
    chk("err_after_gapped", 32'(bus.err), 32'd0);

    // Random overlapping sections
    for (int s = 0; s < 6; s++) begin
      tgt = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 24);
      fill_random(len);
      load_section(tgt, 12'(len), 2);
    end
    idle(1);
    #1;
    check_mem();
    chk("never_both_strobes", 32'(both_hi), 32'd0);
    chk("no_overflow_yet", 32'(bus.overflow), 32'd0);

    // Start command and cool-off timing
    put(8'h47);
    chk("cooloff_in_ready", 32'(bus.in_ready), 32'd0);
    chk("cooloff_cpu_k0", 32'(bus.cpu_reset_), 32'd0);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      chk("cpu_release_timing", 32'(bus.cpu_reset_), (k >= COOLOFF) ? 32'd1 : 32'd0);
    end
    repeat (3) @(negedge clk);
    chk("run_in_ready", 32'(bus.in_ready), 32'd0);
    chk("run_no_strobe", {30'd0, bus.i_wr, bus.m_wr}, 32'd0);
    reset = 1'b1;
    #1;
    chk("run_reset_cpu", 32'(bus.cpu_reset_), 32'd0);
    chk("run_reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Full-length data section overruns the top of memory
    n0 = n_mwr;
    fill_random(2048);
    load_section(1'b1, 12'h800, 0);
    idle(1);
    #1;
    chk("overflow_write_count", 32'(n_mwr - n0), 32'd2040);
    chk("overflow_sticky", 32'(bus.overflow), 32'd1);
    chk("overflow_back_idle", 32'(bus.in_ready & ~bus.busy), 32'd1);
    check_mem();

    // Zero-length section, then bad command
    pulse_reset();
    chk("overflow_cleared", 32'(bus.overflow), 32'd0);
    put(8'h49); put(8'h00); put(8'h00);
    chk("zero_len_idle", 32'(bus.busy), 32'd0);
    n0 = n_iwr + n_mwr;
    put(8'h5A);
    chk("bad_cmd_err", 32'(bus.err), 32'd1);
    chk("err_in_ready", 32'(bus.in_ready), 32'd1);
    put(8'h47);
    put(8'h12);
    idle(40);
    #1;
    chk("err_no_writes", 32'(n_iwr + n_mwr - n0), 32'd0);
    chk("err_cpu_held", 32'(bus.cpu_reset_), 32'd0);
    chk("err_sticky", 32'(bus.err), 32'd1);

    // Bad length-high nibble
    pulse_reset();
    chk("err_cleared", 32'(bus.err), 32'd0);
    put(8'h49); put(8'h10);
    chk("len_hi_err", 32'(bus.err), 32'd1);
    put(8'h47);
    idle(40);
    chk("len_hi_cpu_held", 32'(bus.cpu_reset_), 32'd0);

    // Reset in the middle of a payload
    pulse_reset();
    put(8'h49); put(8'h00); put(8'h0A);
    for (int k = 0; k < 4; k++) begin
      pay[0] = 8'($urandom);
      put(pay[0]);
      chk("mid_i_wr", 32'(bus.i_wr), 32'd1);
      model_i[k] = pay[0];
    end
    reset = 1'b1;
    #1;
    chk("mid_rst_i_wr", 32'(bus.i_wr), 32'd0);
    chk("mid_rst_i_addr", 32'(bus.i_addr), 32'd0);
    chk("mid_rst_i_wr_data", 32'(bus.i_wr_data), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reload after reset
    fill_random(5);
    load_section(1'b0, 12'd5, 2);
    fill_random(3);
    load_section(1'b1, 12'd3, 0);
    idle(1);
    #1;
    check_mem();
    chk("final_never_both", 32'(both_hi), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
